// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU op codes, forwarding selects and multiplier states
package cpu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_SUB   = 6'h01;
  localparam logic [5:0] ALU_AND   = 6'h02;
  localparam logic [5:0] ALU_OR    = 6'h03;
  localparam logic [5:0] ALU_XOR   = 6'h04;
  localparam logic [5:0] ALU_NOR   = 6'h05;
  localparam logic [5:0] ALU_SLT   = 6'h06;
  localparam logic [5:0] ALU_SLTU  = 6'h07;
  localparam logic [5:0] ALU_SLL   = 6'h08;
  localparam logic [5:0] ALU_SRL   = 6'h09;
  localparam logic [5:0] ALU_SRA   = 6'h0A;
  localparam logic [5:0] ALU_LUI   = 6'h0B;
  localparam logic [5:0] ALU_MULT  = 6'h0C;
  localparam logic [5:0] ALU_MULTU = 6'h0D;
  localparam logic [5:0] ALU_MFHI  = 6'h0E;
  localparam logic [5:0] ALU_MFLO  = 6'h0F;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_BUSY = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/ex_stage_pipe_if.sv
// rtl/ex_stage_pipe_if.sv - ID-side inputs and EX-side outputs of the execute stage
interface ex_stage_pipe_if #(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int ALUC_W = 6
);
  logic              id_valid;
  logic [XLEN-1:0]   id_a, id_b, id_imm, id_pc4;
  logic [ALUC_W-1:0] id_aluc;
  logic              id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch;
  logic [REGW-1:0]   id_destR;
  logic [1:0]        id_fwda, id_fwdb;
  logic [XLEN-1:0]   mem_fwd_data, wb_fwd_data;
  logic              flush;

  logic              ex_valid;
  logic              ex_wreg, ex_m2reg, ex_wmem, ex_branch;
  logic [XLEN-1:0]   ex_aluR, ex_inB, ex_pc;
  logic              ex_zero;
  logic [REGW-1:0]   ex_destR;
  logic              ex_stall;

  modport slave (
    input  id_valid, id_a, id_b, id_imm, id_pc4, id_aluc,
           id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch,
           id_destR, id_fwda, id_fwdb, mem_fwd_data, wb_fwd_data, flush,
    output ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch,
           ex_aluR, ex_inB, ex_pc, ex_zero, ex_destR, ex_stall
  );

  modport master (
    output id_valid, id_a, id_b, id_imm, id_pc4, id_aluc,
           id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem, id_branch,
           id_destR, id_fwda, id_fwdb, mem_fwd_data, wb_fwd_data, flush,
    input  ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_branch,
           ex_aluR, ex_inB, ex_pc, ex_zero, ex_destR, ex_stall
  );
endinterface

// File: rtl/ex_mul_iter.sv
// rtl/ex_mul_iter.sv - iterative shift-add multiplier, MUL_BITS_PER_CYC multiplier bits per cycle
module ex_mul_iter #(
  parameter int XLEN             = 32,
  parameter int MUL_BITS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              start,
  input  logic              signed_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  import cpu_pkg::*;

  localparam int MUL_LAT = XLEN / MUL_BITS_PER_CYC;
  localparam int CW      = $clog2(MUL_LAT) + 1;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic              r_neg;
  logic [XLEN-1:0]   w_ma, w_mb;
  logic [2*XLEN-1:0] w_part;

  // Signed multiply works on magnitudes; the sign is reapplied on the product.
  assign w_ma = (signed_op && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign w_mb = (signed_op && b[XLEN-1]) ? (~b + 1'b1) : b;

  always_comb begin
    w_part = '0;
    for (int j = 0; j < MUL_BITS_PER_CYC; j++)
      if (r_mplier[j]) w_part = w_part + (r_mcand << j);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= MUL_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        MUL_IDLE: if (start) begin
          r_mcand  <= {{XLEN{1'b0}}, w_ma};
          r_mplier <= w_mb;
          r_neg    <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
          r_acc    <= '0;
          r_cnt    <= CW'(MUL_LAT);
          r_state  <= MUL_BUSY;
        end
        MUL_BUSY: begin
          r_acc    <= r_acc + w_part;
          r_mcand  <= r_mcand << MUL_BITS_PER_CYC;
          r_mplier <= r_mplier >> MUL_BITS_PER_CYC;
          if (r_cnt == CW'(1)) r_state <= MUL_DONE;
          else                 r_cnt   <= r_cnt - 1'b1;
        end
        MUL_DONE: r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == MUL_BUSY);
  assign done    = (r_state == MUL_DONE);
  assign product = r_neg ? (~r_acc + 1'b1) : r_acc;
endmodule

// File: rtl/ex_stage_pipe.sv
// rtl/ex_stage_pipe.sv - pipelined execute stage: ID/EX register, forwarding, ALU, branch target, HI/LO multiply
module ex_stage_pipe #(
  parameter int XLEN             = 32,
  parameter int REGW             = 5,
  parameter int MUL_BITS_PER_CYC = 1,
  parameter int ALUC_W           = 6
) (
  input logic            clk,
  input logic            clrn,
  ex_stage_pipe_if.slave bus
);
  import cpu_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic              r_valid;
  logic [XLEN-1:0]   r_a, r_b, r_imm, r_pc4;
  logic [ALUC_W-1:0] r_aluc;
  logic              r_aluimm, r_shift, r_wreg, r_m2reg, r_wmem, r_branch;
  logic [REGW-1:0]   r_destR;
  logic [1:0]        r_fwda, r_fwdb;
  logic [XLEN-1:0]   r_hi, r_lo;

  logic [XLEN-1:0]   w_fwd_a, w_fwd_b, w_alu_a, w_alu_b, w_alu;
  logic [SHW-1:0]    w_sh;
  logic              w_is_mul, w_mul_start, w_busy, w_done, w_stall;
  logic [2*XLEN-1:0] w_product;

  always_comb begin
    case (r_fwda)
      FWD_MEM: w_fwd_a = bus.mem_fwd_data;
      FWD_WB:  w_fwd_a = bus.wb_fwd_data;
      default: w_fwd_a = r_a;
    endcase
    case (r_fwdb)
      FWD_MEM: w_fwd_b = bus.mem_fwd_data;
      FWD_WB:  w_fwd_b = bus.wb_fwd_data;
      default: w_fwd_b = r_b;
    endcase
  end

  assign w_alu_a = r_shift  ? {{(XLEN-5){1'b0}}, r_imm[10:6]} : w_fwd_a;
  assign w_alu_b = r_aluimm ? r_imm : w_fwd_b;
  assign w_sh    = w_alu_a[SHW-1:0];

  always_comb begin
    case (r_aluc)
      ALU_ADD:  w_alu = w_alu_a + w_alu_b;
      ALU_SUB:  w_alu = w_alu_a - w_alu_b;
      ALU_AND:  w_alu = w_alu_a & w_alu_b;
      ALU_OR:   w_alu = w_alu_a | w_alu_b;
      ALU_XOR:  w_alu = w_alu_a ^ w_alu_b;
      ALU_NOR:  w_alu = ~(w_alu_a | w_alu_b);
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_alu_a) < $signed(w_alu_b))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_alu_a < w_alu_b)};
      ALU_SLL:  w_alu = w_alu_b << w_sh;
      ALU_SRL:  w_alu = w_alu_b >> w_sh;
      ALU_SRA:  w_alu = $unsigned($signed(w_alu_b) >>> w_sh);
      ALU_LUI:  w_alu = r_imm << (XLEN/2);
      ALU_MFHI: w_alu = r_hi;
      ALU_MFLO: w_alu = r_lo;
      default:  w_alu = '0;
    endcase
  end

  // The multiply starts from IDLE only; in DONE the MULT is still in EX and must not restart.
  assign w_is_mul    = (r_aluc == ALU_MULT) || (r_aluc == ALU_MULTU);
  assign w_mul_start = r_valid && w_is_mul && !bus.flush && !w_busy && !w_done;
  assign w_stall     = w_mul_start || w_busy;

  ex_mul_iter #(.XLEN(XLEN), .MUL_BITS_PER_CYC(MUL_BITS_PER_CYC)) u_mul (
    .clk       (clk),
    .clrn      (clrn),
    .start     (w_mul_start),
    .signed_op (r_aluc == ALU_MULT),
    .a         (w_fwd_a),
    .b         (w_fwd_b),
    .busy      (w_busy),
    .done      (w_done),
    .product   (w_product)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= 1'b0;  r_a <= '0;  r_b <= '0;  r_imm <= '0;  r_pc4 <= '0;
      r_aluc <= '0;  r_aluimm <= 1'b0;  r_shift <= 1'b0;  r_wreg <= 1'b0;
      r_m2reg <= 1'b0;  r_wmem <= 1'b0;  r_branch <= 1'b0;  r_destR <= '0;
      r_fwda <= FWD_REG;  r_fwdb <= FWD_REG;
    end else if (bus.flush && !w_busy) begin
      r_valid <= 1'b0;  r_aluc <= '0;  r_aluimm <= 1'b0;  r_shift <= 1'b0;
      r_wreg <= 1'b0;  r_m2reg <= 1'b0;  r_wmem <= 1'b0;  r_branch <= 1'b0;
      r_fwda <= FWD_REG;  r_fwdb <= FWD_REG;
    end else if (!w_stall) begin
      r_valid <= bus.id_valid;  r_a <= bus.id_a;  r_b <= bus.id_b;
      r_imm <= bus.id_imm;  r_pc4 <= bus.id_pc4;  r_aluc <= bus.id_aluc;
      r_aluimm <= bus.id_aluimm;  r_shift <= bus.id_shift;  r_wreg <= bus.id_wreg;
      r_m2reg <= bus.id_m2reg;  r_wmem <= bus.id_wmem;  r_branch <= bus.id_branch;
      r_destR <= bus.id_destR;  r_fwda <= bus.id_fwda;  r_fwdb <= bus.id_fwdb;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      {r_hi, r_lo} <= w_product;
    end
  end

  assign bus.ex_valid  = r_valid;
  assign bus.ex_wreg   = r_valid & r_wreg & ~w_is_mul;
  assign bus.ex_m2reg  = r_valid & r_m2reg;
  assign bus.ex_wmem   = r_valid & r_wmem;
  assign bus.ex_branch = r_valid & r_branch;
  assign bus.ex_aluR   = w_alu;
  assign bus.ex_inB    = w_fwd_b;
  assign bus.ex_pc     = r_pc4 + (r_imm << 2);
  assign bus.ex_zero   = r_valid & (w_fwd_a == w_fwd_b);
  assign bus.ex_destR  = r_destR;
  assign bus.ex_stall  = w_stall;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb/tb_ex_stage_pipe.sv - directed bench for ex_stage_pipe at XLEN=32/1 bit and XLEN=16/4 bits
module tb_ex_stage_pipe;
  import cpu_pkg::*;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.XLEN(32), .REGW(5), .ALUC_W(6)) b32 ();
  ex_stage_pipe_if #(.XLEN(16), .REGW(5), .ALUC_W(6)) b16 ();

  ex_stage_pipe #(.XLEN(32), .REGW(5), .MUL_BITS_PER_CYC(1), .ALUC_W(6)) u32 (
    .clk(clk), .clrn(clrn), .bus(b32));
  ex_stage_pipe #(.XLEN(16), .REGW(5), .MUL_BITS_PER_CYC(4), .ALUC_W(6)) u16 (
    .clk(clk), .clrn(clrn), .bus(b16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op32(input logic [5:0] aluc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [4:0] dest, input logic wreg);
    b32.id_valid = 1'b1;  b32.id_aluc = aluc;  b32.id_a = a;  b32.id_b = b;
    b32.id_imm = imm;  b32.id_pc4 = '0;  b32.id_destR = dest;  b32.id_wreg = wreg;
    b32.id_aluimm = 1'b0;  b32.id_shift = 1'b0;  b32.id_m2reg = 1'b0;
    b32.id_wmem = 1'b0;  b32.id_branch = 1'b0;  b32.id_fwda = FWD_REG;
    b32.id_fwdb = FWD_REG;  b32.flush = 1'b0;
  endtask

  task automatic op16(input logic [5:0] aluc, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] imm);
    b16.id_valid = 1'b1;  b16.id_aluc = aluc;  b16.id_a = a;  b16.id_b = b;
    b16.id_imm = imm;  b16.id_pc4 = '0;  b16.id_destR = 5'd1;  b16.id_wreg = 1'b1;
    b16.id_aluimm = 1'b0;  b16.id_shift = 1'b0;  b16.id_m2reg = 1'b0;
    b16.id_wmem = 1'b0;  b16.id_branch = 1'b0;  b16.id_fwda = FWD_REG;
    b16.id_fwdb = FWD_REG;  b16.flush = 1'b0;
    b16.mem_fwd_data = '0;  b16.wb_fwd_data = '0;
  endtask

  task automatic wait_stall32(output int n);
    n = 0;
    while (b32.ex_stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    op32(ALU_ADD, 0, 0, 0, 0, 0);
    b32.id_valid = 1'b0;  b32.mem_fwd_data = '0;  b32.wb_fwd_data = '0;
    op16(ALU_ADD, 0, 0, 0);
    b16.id_valid = 1'b0;
    clrn = 1'b0;
    tick();
    tick();
    n_run++; if (b32.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b32.ex_valid); end
    n_run++; if (b32.ex_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", b32.ex_stall); end
    n_run++; if (b32.ex_destR !== 5'd0) begin n_fail++; $display("FAIL reset_destR: got %h want 0", b32.ex_destR); end
    n_run++; if ({b32.ex_wreg, b32.ex_m2reg, b32.ex_wmem, b32.ex_branch, b32.ex_zero} !== 5'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {b32.ex_wreg, b32.ex_m2reg, b32.ex_wmem, b32.ex_branch, b32.ex_zero}); end
    n_run++; if (b32.ex_aluR !== 32'h0 || b32.ex_pc !== 32'h0) begin n_fail++; $display("FAIL reset_data: aluR %h pc %h want 0 0", b32.ex_aluR, b32.ex_pc); end
    n_run++; if (b16.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset16_valid: got %b want 0", b16.ex_valid); end
    clrn = 1'b1;
  endtask

  task automatic test_forwarding;
    op32(ALU_ADD, 5, 3, 0, 5'd3, 1'b1);
    b32.id_fwda = FWD_MEM;  b32.mem_fwd_data = 32'd7;
    tick();
    n_run++; if (b32.ex_aluR !== 32'h0000000A) begin n_fail++; $display("FAIL fwd_mem_a: got %h want 0000000a", b32.ex_aluR); end
    n_run++; if (b32.ex_wreg !== 1'b1 || b32.ex_destR !== 5'd3) begin n_fail++; $display("FAIL fwd_ctrl: wreg %b destR %0d want 1 3", b32.ex_wreg, b32.ex_destR); end
    n_run++; if (b32.ex_inB !== 32'd3) begin n_fail++; $display("FAIL fwd_inB_reg: got %h want 3", b32.ex_inB); end

    op32(ALU_ADD, 5, 3, 0, 5'd4, 1'b1);
    b32.id_fwda = FWD_WB;  b32.wb_fwd_data = 32'd1;
    tick();
    n_run++; if (b32.ex_aluR !== 32'd4) begin n_fail++; $display("FAIL fwd_wb_a: got %h want 4", b32.ex_aluR); end

    op32(ALU_ADD, 5, 3, 0, 5'd4, 1'b1);
    b32.id_fwda = 2'd3;  b32.id_fwdb = FWD_MEM;  b32.mem_fwd_data = 32'd7;
    tick();
    n_run++; if (b32.ex_aluR !== 32'd12) begin n_fail++; $display("FAIL fwd_reserved_a_mem_b: got %h want c", b32.ex_aluR); end
    n_run++; if (b32.ex_inB !== 32'd7) begin n_fail++; $display("FAIL fwd_inB_mem: got %h want 7", b32.ex_inB); end

    op32(6'h3F, 5, 3, 0, 5'd4, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'd0) begin n_fail++; $display("FAIL undef_aluc: got %h want 0", b32.ex_aluR); end
  endtask

  task automatic test_branch_flush;
    op32(ALU_SUB, 9, 9, 32'hFFFF_FFFF, 5'd0, 1'b0);
    b32.id_pc4 = 32'h100;  b32.id_branch = 1'b1;
    tick();
    n_run++; if (b32.ex_pc !== 32'h0000_00FC) begin n_fail++; $display("FAIL branch_target: got %h want 000000fc", b32.ex_pc); end
    n_run++; if (b32.ex_zero !== 1'b1 || b32.ex_branch !== 1'b1) begin n_fail++; $display("FAIL branch_zero: zero %b branch %b want 1 1", b32.ex_zero, b32.ex_branch); end

    op32(ALU_ADD, 1, 2, 0, 5'd6, 1'b1);
    b32.flush = 1'b1;
    tick();
    b32.flush = 1'b0;
    n_run++; if (b32.ex_valid !== 1'b0 || b32.ex_wreg !== 1'b0 || b32.ex_branch !== 1'b0)
      begin n_fail++; $display("FAIL flush: valid %b wreg %b branch %b want 0 0 0", b32.ex_valid, b32.ex_wreg, b32.ex_branch); end

    op32(ALU_SUB, 9, 8, 0, 5'd0, 1'b0);
    tick();
    n_run++; if (b32.ex_zero !== 1'b0) begin n_fail++; $display("FAIL branch_nonzero: got %b want 0", b32.ex_zero); end
  endtask

  task automatic test_mult_stall_hold;
    int cyc;
    op32(ALU_MULT, 32'hFFFF_FFFD, 32'd4, 0, 5'd7, 1'b1);
    tick();
    cyc = 0;
    while (b32.ex_stall === 1'b1 && cyc < 200) begin
      n_run++;
      if (b32.ex_destR !== 5'd7 || b32.ex_valid !== 1'b1 || b32.ex_wreg !== 1'b0 || b32.ex_wmem !== 1'b0)
        begin n_fail++; $display("FAIL stall_hold cyc %0d: destR %0d valid %b wreg %b wmem %b want 7 1 0 0", cyc, b32.ex_destR, b32.ex_valid, b32.ex_wreg, b32.ex_wmem); end
      b32.id_destR = 5'(cyc + 8);
      b32.id_wreg  = 1'(cyc & 1);
      b32.id_wmem  = 1'b1;
      b32.id_a     = 32'(cyc);
      b32.id_aluc  = ALU_ADD;
      b32.flush    = (cyc == 5);
      cyc++;
      tick();
    end
    b32.flush = 1'b0;
    n_run++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_stall_len: got %0d want 33", cyc); end
    n_run++; if (b32.ex_destR !== 5'd7) begin n_fail++; $display("FAIL done_hold_destR: got %0d want 7", b32.ex_destR); end

    op32(ALU_MFLO, 0, 0, 0, 5'd9, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'hFFFF_FFF4) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff4", b32.ex_aluR); end
    n_run++; if (b32.ex_destR !== 5'd9) begin n_fail++; $display("FAIL after_done_destR: got %0d want 9", b32.ex_destR); end
    op32(ALU_MFHI, 0, 0, 0, 5'd9, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", b32.ex_aluR); end

    op32(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 5'd1, 1'b1);
    tick();
    wait_stall32(cyc);
    n_run++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_stall_len: got %0d want 33", cyc); end
    op32(ALU_MFHI, 0, 0, 0, 5'd2, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h want 1", b32.ex_aluR); end
    op32(ALU_MFLO, 0, 0, 0, 5'd2, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", b32.ex_aluR); end
  endtask

  task automatic test_async_reset;
    int cyc;
    op32(ALU_MULT, 32'd5, 32'd6, 0, 5'd11, 1'b1);
    tick();
    repeat (10) tick();
    n_run++; if (b32.ex_stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b want 1", b32.ex_stall); end
    clrn = 1'b0;
    #1;
    n_run++; if (b32.ex_stall !== 1'b0 || b32.ex_valid !== 1'b0 || b32.ex_destR !== 5'd0 || b32.ex_aluR !== 32'd0)
      begin n_fail++; $display("FAIL async_reset: stall %b valid %b destR %0d aluR %h want 0 0 0 0", b32.ex_stall, b32.ex_valid, b32.ex_destR, b32.ex_aluR); end
    b32.id_valid = 1'b0;
    tick();
    clrn = 1'b1;
    op32(ALU_MFHI, 0, 0, 0, 5'd3, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", b32.ex_aluR); end
    op32(ALU_MFLO, 0, 0, 0, 5'd3, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", b32.ex_aluR); end

    op32(ALU_MULT, 32'd5, 32'd6, 0, 5'd11, 1'b1);
    tick();
    wait_stall32(cyc);
    n_run++; if (cyc !== 33) begin n_fail++; $display("FAIL post_reset_stall_len: got %0d want 33", cyc); end
    op32(ALU_MFLO, 0, 0, 0, 5'd3, 1'b1);
    tick();
    n_run++; if (b32.ex_aluR !== 32'd30) begin n_fail++; $display("FAIL post_reset_lo: got %h want 1e", b32.ex_aluR); end
  endtask

  task automatic test_param16;
    int cyc;
    op16(ALU_SRA, 16'h0, 16'h8000, 16'h03C0);
    b16.id_shift = 1'b1;
    tick();
    n_run++; if (b16.ex_aluR !== 16'hFFFF) begin n_fail++; $display("FAIL sra16: got %h want ffff", b16.ex_aluR); end
    op16(ALU_SLT, 16'h8000, 16'h0001, 16'h0);
    tick();
    n_run++; if (b16.ex_aluR !== 16'h0001) begin n_fail++; $display("FAIL slt16: got %h want 0001", b16.ex_aluR); end
    op16(ALU_SLTU, 16'h8000, 16'h0001, 16'h0);
    tick();
    n_run++; if (b16.ex_aluR !== 16'h0000) begin n_fail++; $display("FAIL sltu16: got %h want 0000", b16.ex_aluR); end

    op16(ALU_MULT, 16'hFFFD, 16'h0005, 16'h0);
    tick();
    cyc = 0;
    while (b16.ex_stall === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    n_run++; if (cyc !== 5) begin n_fail++; $display("FAIL mult16_stall_len: got %0d want 5", cyc); end
    op16(ALU_MFLO, 0, 0, 0);
    tick();
    n_run++; if (b16.ex_aluR !== 16'hFFF1) begin n_fail++; $display("FAIL mult16_lo: got %h want fff1", b16.ex_aluR); end
    op16(ALU_MFHI, 0, 0, 0);
    tick();
    n_run++; if (b16.ex_aluR !== 16'hFFFF) begin n_fail++; $display("FAIL mult16_hi: got %h want ffff", b16.ex_aluR); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_branch_flush();
    test_mult_stall_hold();
    test_async_reset();
    test_param16();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
